// File: rtl/fmcw_dsp_pkg.sv
// Shared helpers for the FMCW receive DSP blocks: constant-width arithmetic
// used to size datapaths at elaboration time.
package fmcw_dsp_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision accumulator width of a symmetric FIR: pre-add, multiply, tree growth.
  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + 1 + coef_w + clog2(ntaps / 2);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Pipelined binary adder tree: one register level per halving, valid tag
// travelling alongside the partial sums. Inputs beyond N are treated as zero.
module fir_adder_tree
  import fmcw_dsp_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             vld_in,
  input  logic [N*W-1:0]   din,
  output logic             vld_out,
  output logic [W-1:0]     dout
);

  localparam int L  = clog2(N);
  localparam int NP = 1 << L;

  logic [NP*W-1:0]     din_pad;
  logic signed [W-1:0] leaf [NP];
  logic signed [W-1:0] lvl  [L][NP];
  logic [L-1:0]        vld_sr;

  assign din_pad = (NP*W)'(din);

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      leaf[i] = $signed(din_pad[i*W +: W]);
    end
  end

  // Tree levels: level lv holds NP >> (lv+1) partial sums
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_sr <= '0;
      for (int lv = 0; lv < L; lv++) begin
        for (int i = 0; i < NP; i++) begin
          lvl[lv][i] <= '0;
        end
      end
    end else begin
      vld_sr <= L'({vld_sr, vld_in});
      for (int lv = 0; lv < L; lv++) begin
        for (int i = 0; i < (NP >> (lv + 1)); i++) begin
          if (lv == 0) begin
            lvl[lv][i] <= leaf[2*i] + leaf[2*i+1];
          end else begin
            lvl[lv][i] <= lvl[(lv > 0) ? lv - 1 : 0][2*i] + lvl[(lv > 0) ? lv - 1 : 0][2*i+1];
          end
        end
      end
    end
  end

  assign vld_out = vld_sr[L-1];
  assign dout    = lvl[L-1][0];

endmodule

// File: rtl/fir_sym_decim.sv
// Symmetric linear-phase FIR with double-buffered runtime coefficients,
// integer decimation and a round/shift/saturate output stage.
module fir_sym_decim
  import fmcw_dsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 12,
  parameter int NTAPS  = 16,
  parameter int DECIM  = 1,
  parameter int OUT_W  = 28,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [clog2(NTAPS/2)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  input  logic                      coef_commit,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic                      sat_flag
);

  localparam int NH     = NTAPS / 2;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int RW     = ACC_W + 1;
  localparam int MW     = ((RW > OUT_W) ? RW : OUT_W) + 1;

  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] v);
    logic signed [RW-1:0] t;
    t = RW'(v) + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic is_sat(input logic signed [RW-1:0] v);
    logic signed [MW-1:0] e;
    e = MW'(v);
    return (e > SAT_MAX) || (e < SAT_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic signed [RW-1:0] v);
    logic signed [MW-1:0] e;
    e = MW'(v);
    if (e > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (e < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return e[OUT_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] h_shadow [NH];
  logic signed [COEF_W-1:0] h_active [NH];
  logic signed [DATA_W-1:0] x_p1     [NTAPS];
  logic                     vld_p1;
  logic [7:0]               phase;
  logic signed [PRE_W-1:0]  pre_p2   [NH];
  logic                     vld_p2;
  logic signed [PROD_W-1:0] prod_p3  [NH];
  logic                     vld_p3;
  logic [NH*ACC_W-1:0]      prod_flat;
  logic                     vld_tree;
  logic [ACC_W-1:0]         sum_tree;
  logic signed [RW-1:0]     rs_out;

  // Coefficient banks: a commit copies the pre-write shadow contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NH; k++) begin
        h_shadow[k] <= '0;
        h_active[k] <= '0;
      end
    end else begin
      if (coef_commit) begin
        for (int k = 0; k < NH; k++) h_active[k] <= h_shadow[k];
      end
      if (coef_we && (int'(coef_addr) < NH)) begin
        h_shadow[coef_addr] <= $signed(coef_wdata);
      end
    end
  end

  // S1: delay line and decimation tagging
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < NTAPS; k++) x_p1[k] <= '0;
      vld_p1 <= 1'b0;
      phase  <= '0;
    end else begin
      vld_p1 <= in_valid && (phase == 8'd0);
      if (in_valid) begin
        x_p1[0] <= $signed(in_data);
        for (int k = 1; k < NTAPS; k++) x_p1[k] <= x_p1[k-1];
        phase <= (phase == 8'(DECIM - 1)) ? 8'd0 : phase + 8'd1;
      end
    end
  end

  // S2: symmetric pre-add; S3: multiply by the active bank
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < NH; k++) begin
        pre_p2[k]  <= '0;
        prod_p3[k] <= '0;
      end
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      for (int k = 0; k < NH; k++) begin
        pre_p2[k]  <= PRE_W'(x_p1[k]) + PRE_W'(x_p1[NTAPS-1-k]);
        prod_p3[k] <= PROD_W'(pre_p2[k]) * PROD_W'(h_active[k]);
      end
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_comb begin
    prod_flat = '0;
    for (int k = 0; k < NH; k++) begin
      prod_flat[k*ACC_W +: ACC_W] = ACC_W'(prod_p3[k]);
    end
  end

  // S4..S3+L: registered adder tree
  fir_adder_tree #(
    .N (NH),
    .W (ACC_W)
  ) u_tree (
    .clk     (clk),
    .clr     (rst | flush),
    .vld_in  (vld_p3),
    .din     (prod_flat),
    .vld_out (vld_tree),
    .dout    (sum_tree)
  );

  assign rs_out = round_shift($signed(sum_tree));

  // S4+L: round, shift, saturate
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= vld_tree;
      if (vld_tree) begin
        out_data <= saturate(rs_out);
        if (is_sat(rs_out)) sat_flag <= 1'b1;
      end
    end
  end

endmodule
